// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type and ALU opcode encoding for the execute stage
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - ALU operand/result bundle with design and bench views
interface alu_if;
    import cpu_types_pkg::*;

    aluop_t ALUOP;
    word_t  A;
    word_t  B;
    word_t  O;
    logic   N;
    logic   Z;
    logic   V;

    modport alu (input ALUOP, A, B, output O, N, Z, V);
    modport tb  (output ALUOP, A, B, input O, N, Z, V);

endinterface

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared 32-bit adder; sub inverts b and injects carry-in
module alu_addsub
    import cpu_types_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  sub,
    output word_t sum,
    output logic  overflow
);

    word_t b_eff;

    always_comb begin
        b_eff    = sub ? ~b : b;
        sum      = a + b_eff + {{(WORD_W-1){1'b0}}, sub};
        // Same-sign effective operands producing a different-sign result
        overflow = (a[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit MIPS ALU with registered {N,Z,V} status copy
module alu
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  aluop_t     ALUOP,
    input  word_t      A,
    input  word_t      B,
    output word_t      O,
    output logic       N,
    output logic       Z,
    output logic       V,
    output logic [2:0] FLAGS_Q
);

    word_t as_sum;
    logic  as_ovf;
    logic  as_sub;
    logic  slt_bit;

    // Only ADD adds; SUB and SLT both need A - B
    assign as_sub = (ALUOP != ALU_ADD);

    alu_addsub u_addsub (
        .a        (A),
        .b        (B),
        .sub      (as_sub),
        .sum      (as_sum),
        .overflow (as_ovf)
    );

    assign slt_bit = as_sum[WORD_W-1] ^ as_ovf;

    always_comb begin
        O = '0;
        V = 1'b0;
        case (ALUOP)
            ALU_SLL:  O = A << B[4:0];
            ALU_SRL:  O = A >> B[4:0];
            ALU_ADD:  begin O = as_sum; V = as_ovf; end
            ALU_SUB:  begin O = as_sum; V = as_ovf; end
            ALU_AND:  O = A & B;
            ALU_OR:   O = A | B;
            ALU_XOR:  O = A ^ B;
            ALU_NOR:  O = ~(A | B);
            ALU_SLT:  O = {{(WORD_W-1){1'b0}}, slt_bit};
            ALU_SLTU: O = {{(WORD_W-1){1'b0}}, (A < B)};
            default:  begin O = '0; V = 1'b0; end
        endcase
    end

    assign N = O[WORD_W-1];
    assign Z = (O == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FLAGS_Q <= 3'b000;
        end else begin
            FLAGS_Q <= {N, Z, V};
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed vectors against hand values plus a per-cycle arithmetic model
module tb_alu;
    import cpu_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    aluop_t     aluop = ALU_SLL;
    word_t      a = '0;
    word_t      b = '0;
    word_t      o;
    logic       n, z, v;
    logic [2:0] flags_q;

    int n_cmp = 0;
    int n_bad = 0;
    logic started = 1'b0;
    logic [2:0] exp_fq = 3'b000;

    alu dut (
        .CLK     (clk),
        .RST     (rst),
        .ALUOP   (aluop),
        .A       (a),
        .B       (b),
        .O       (o),
        .N       (n),
        .Z       (z),
        .V       (v),
        .FLAGS_Q (flags_q)
    );

    always #5 clk = ~clk;

    // Model: {O, N, Z, V} from plain integer arithmetic
    function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, r;
        logic [31:0] res;
        logic ovf;
        logic [4:0] sh;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sh  = y[4:0];
        res = 32'd0;
        ovf = 1'b0;
        r   = 0;
        case (op)
            4'd0: res = x << sh;
            4'd1: res = x >> sh;
            4'd2: begin r = sx + sy; res = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd3: begin r = sx - sy; res = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd4: res = x & y;
            4'd5: res = x | y;
            4'd6: res = x ^ y;
            4'd7: res = ~(x | y);
            4'd8: res = (sx < sy) ? 32'd1 : 32'd0;
            4'd9: res = (x < y) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        return {res, res[31], (res == 32'd0), ovf};
    endfunction

    function automatic logic [2:0] model_flags(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [34:0] m;
        m = model(op, x, y);
        return m[2:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_fq <= 3'b000;
        else     exp_fq <= model_flags(aluop, a, b);
    end

    always @(negedge clk) begin
        if (started) begin
            logic [34:0] m;
            m = model(aluop, a, b);
            n_cmp++;
            if ({o, n, z, v} !== m) begin
                n_bad++;
                $display("FAIL model_onzv op=%0d a=%h b=%h: got %h/%b%b%b expected %h/%b%b%b",
                         aluop, a, b, o, n, z, v, m[34:3], m[2], m[1], m[0]);
            end
            n_cmp++;
            if (flags_q !== exp_fq) begin
                n_bad++;
                $display("FAIL model_flags_q: got %b expected %b", flags_q, exp_fq);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic vec(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_o, input logic [2:0] exp_nzv);
        @(posedge clk);
        #1;
        aluop = aluop_t'(op);
        a = x;
        b = y;
        #1;
        check({name, "_o"}, o, exp_o);
        check({name, "_nzv"}, {29'd0, n, z, v}, {29'd0, exp_nzv});
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check("reset_flags_q", {29'd0, flags_q}, 32'd0);
        started = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        vec("sll4",      4'd0, 32'h8000_0001, 32'h0000_0004, 32'h0000_0010, 3'b000);
        vec("srl4",      4'd1, 32'h8000_0001, 32'h0000_0004, 32'h0800_0000, 3'b000);
        vec("sll_hi_b",  4'd0, 32'h8000_0001, 32'h0000_0024, 32'h0000_0010, 3'b000);
        vec("srl_hi_b",  4'd1, 32'h8000_0001, 32'h0000_0024, 32'h0800_0000, 3'b000);
        vec("sll0",      4'd0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 3'b000);
        vec("srl31",     4'd1, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 3'b000);
        vec("add_2_4",   4'd2, 32'd2, 32'd4, 32'd6, 3'b000);
        vec("sub_2_4",   4'd3, 32'd2, 32'd4, 32'hFFFF_FFFE, 3'b100);
        vec("sub_9_9",   4'd3, 32'd9, 32'd9, 32'd0, 3'b010);
        vec("add_9_9",   4'd2, 32'd9, 32'd9, 32'd18, 3'b000);
        vec("add_ovf",   4'd2, 32'h8000_0000, 32'h8000_0000, 32'd0, 3'b011);
        vec("sub_ovf",   4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 3'b001);
        vec("sub_ovf2",  4'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 3'b101);
        vec("add_10_10", 4'd2, 32'd10, 32'd10, 32'd20, 3'b000);
        vec("and",       4'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 3'b000);
        vec("or",        4'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 3'b100);
        vec("xor",       4'd6, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 3'b100);
        vec("nor",       4'd7, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00, 3'b000);
        vec("slt",       4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 3'b000);
        vec("sltu",      4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b010);
        vec("slt_swap",  4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 3'b010);
        vec("sltu_swap", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd1, 3'b000);

        vec("sub_neg",   4'd3, 32'd2, 32'd4, 32'hFFFF_FFFE, 3'b100);
        @(posedge clk); #1;
        check("flags_q_neg", {29'd0, flags_q}, {29'd0, 3'b100});
        rst = 1'b1;
        #1 check("flags_q_async_rst", {29'd0, flags_q}, 32'd0);
        @(posedge clk); #1;
        check("flags_q_held_rst", {29'd0, flags_q}, 32'd0);
        rst = 1'b0;
        aluop = ALU_SUB;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk); #1;
        check("flags_q_sub99", {29'd0, flags_q}, {29'd0, 3'b010});

        vec("illegal_f", 4'hF, 32'h8000_0000, 32'h8000_0000, 32'd0, 3'b010);
        vec("illegal_a", 4'hA, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b010);

        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the MIPS datapath, used in the execute stage.
- Evaluates one of ten operations on operands A and B, driving result O and flags N, Z, V combinationally.
- A registered copy of the flags, clocked by CLK and cleared by RST, is provided for status/debug use.
- Connects through interface alu_if (modports alu and tb).

Parameters:
- none. Width is fixed by word_t (32 bits) from cpu_types_pkg.

Ports:
- CLK  in  1  system clock. Used only by the flag register.
- RST  in  1  reset. One clock; reset is asynchronous and active-high.
- ALUOP  in  4 (aluop_t)  operation select.
- A  in  32 (word_t)  operand A. Also the shift source.
- B  in  32 (word_t)  operand B. B[4:0] is the shift amount.
- O  out  32 (word_t)  result.
- N  out  1  negative flag.
- Z  out  1  zero flag.
- V  out  1  signed overflow flag.
- FLAGS_Q  out  3  registered {N,Z,V}.

Behaviour:
- O, N, Z and V are purely combinational. They settle within the same delta/timestep as the inputs, with no cycle latency.
- ALU_SLL (0): O = A << B[4:0], logical.
- ALU_SRL (1): O = A >> B[4:0], logical, zero fill.
- B[31:5] is ignored by both shifts. A shift of 0 gives O = A.
- ALU_ADD (2): O = A + B, mod 2^32.
- ALU_SUB (3): O = A - B, mod 2^32.
- ALU_AND (4): O = A & B.
- ALU_OR (5): O = A | B.
- ALU_XOR (6): O = A ^ B.
- ALU_NOR (7): O = ~(A | B).
- ALU_SLT (8): O = 32'd1 if $signed(A) < $signed(B), else 0.
- ALU_SLTU (9): O = 32'd1 if A < B unsigned, else 0.
- Codes 10–15: O = 0 and V = 0. Z then reads 1.
- N = O[31] for every opcode.
- Z = (O == 0) for every opcode.
- V on ADD: 1 when A[31] == B[31] and O[31] != A[31].
- V on SUB: 1 when A[31] != B[31] and O[31] != A[31].
- V is 0 for every other opcode.
- FLAGS_Q samples {N,Z,V} on each rising edge of CLK.
- While RST = 1, FLAGS_Q = 3'b000 immediately, regardless of CLK. Capture resumes on the first rising edge after RST falls.
- Reset has no effect on O, N, Z or V.
- X/Z on any input must not produce latches. All outputs are fully assigned on every path (default case).

Decomposition:
- cpu_types_pkg holds:
  - WORD_W = 32 and word_t = logic [31:0].
  - aluop_t, a 4-bit enum: ALU_SLL = 0, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU = 9.
- alu_if.vh declares the interface:
  - Signals: ALUOP, A, B, O, N, Z, V.
  - modport alu: ALUOP/A/B in; O/N/Z/V out.
  - modport tb: the mirror of alu.
- One sub-module is natural: alu_addsub. It is a shared 32-bit adder with B inversion and carry-in for SUB/SLT, and outputs sum and overflow.

Test Plan:
- Shifts: A = 0x8000_0001, B = 4.
  - SLL → O = 0x0000_0010.
  - SRL → O = 0x0800_0000.
  - B = 0x0000_0024 (upper bits ignored, B[4:0] = 4) must give the same two results.
- Arithmetic:
  - ADD 2 + 4 → O = 6, N = 0.
  - SUB 2 − 4 → O = 0xFFFF_FFFE, N = 1.
  - SUB 9 − 9 → O = 0, Z = 1.
  - ADD 9 + 9 → O = 18, Z = 0.
- Overflow:
  - ADD 0x8000_0000 + 0x8000_0000 → O = 0, V = 1, Z = 1.
  - SUB 0x8000_0000 − 0x7FFF_FFFF → O = 1, V = 1.
  - ADD 10 + 10 → V = 0.
- Logic: A = 0xF0F0_1234, B = 0x0FF0_00FF.
  - AND → 0x00F0_0034.
  - OR → 0xFFF0_12FF.
  - XOR → 0xFF00_12CB.
  - NOR → 0x000F_ED00.
- Compare: A = 0xFFFF_FFFF, B = 1.
  - SLT → O = 1 (−1 < 1).
  - SLTU → O = 0.
  - Swap operands: SLT → 0, SLTU → 1.
- Flag register:
  - Assert RST mid-cycle → FLAGS_Q = 0 without a clock edge.
  - Release RST, apply SUB 9 − 9, clock once → FLAGS_Q = 3'b010.
  - Apply illegal ALUOP 4'hF → O = 0, Z = 1, V = 0.
